dec_chain_ctrl: RTL

- Sequencing controller for a chain of decade (BCD 0-9) counter digits. Implements a start/stop/clear stopwatch datapath.
- Contains:
  - a prescaler that derives a count tick from clk;
  - a run-control FSM;
  - carry logic that rolls each digit 9->0 and steps the next digit up.
- Sits above the single-digit decade counter. Drives display/readout logic with a packed BCD value.

---
 rtl/dec_chain_ctrl_pkg.sv | 20 ++
 rtl/dec_chain_ctrl_digit.sv | 28 ++
 rtl/dec_chain_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dec_chain_ctrl_pkg.sv
// Shared types and constants for the decade-chain stopwatch controller.
package dec_chain_ctrl_pkg;

    // Run-control states; 2'b11 is unused and steers back to idle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Next value of one BCD digit; anything at or above 9 rolls to 0.
    function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic inc);
        if (!inc)
            return d;
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/dec_chain_ctrl_digit.sv
// Single BCD decade digit with synchronous clear and ripple carry out.
module bcd_digit
    import dec_chain_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry_out
);

    logic [3:0] r_digit;

    // Digit register: clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_digit <= '0;
        else if (clr)
            r_digit <= '0;
        else
            r_digit <= bcd_next(r_digit, inc);
    end

    assign digit     = r_digit;
    assign carry_out = inc && (r_digit == BCD_MAX);

endmodule

// File: rtl/dec_chain_ctrl.sv
// Stopwatch controller for a chain of BCD digits: prescaler, run FSM,
// carry chaining and sticky overflow.
// Optional lap capture is built when DEC_CHAIN_LAP_EN is defined.
//
// state    | meaning
// IDLE     | stopped and cleared, waiting for start
// RUN      | prescaler advancing, count steps every TICK_DIV cycles
// PAUSE    | count and prescaler frozen, start resumes
module dec_chain_ctrl
    import dec_chain_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 10,
    parameter int DIV_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
`ifdef DEC_CHAIN_LAP_EN
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   lap_count,
    output logic                  lap_valid,
`endif
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  overflow
);

    localparam logic [DIV_W-1:0] PRESC_TC = DIV_W'(TICK_DIV - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DIV_W-1:0]      r_presc;
    logic                  r_running;
    logic                  r_overflow;
    logic                  w_tick;
    logic [DIGITS:0]       w_inc;
    logic [4*DIGITS-1:0]   w_count;

    assign w_tick   = (r_state == ST_RUN) && (r_presc == PRESC_TC);
    assign w_inc[0] = w_tick && !clear;

    // Next-state decode: clear beats stop beats start.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (start) w_state_nxt = ST_RUN;
                ST_RUN:   if (stop)  w_state_nxt = ST_PAUSE;
                ST_PAUSE: if (start) w_state_nxt = ST_RUN;
                default:             w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Prescaler advances only while running and keeps its phase across pause.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_presc <= '0;
        else if (clear)
            r_presc <= '0;
        else if (r_state == ST_RUN)
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end

    // Registered run indicator tracks the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_running <= 1'b0;
        else
            r_running <= (w_state_nxt == ST_RUN);
    end

    // Sticky overflow on carry out of the top digit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_overflow <= 1'b0;
        else if (clear)
            r_overflow <= 1'b0;
        else if (w_inc[DIGITS])
            r_overflow <= 1'b1;
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .reset     (reset),
            .clr       (clear),
            .inc       (w_inc[g]),
            .digit     (w_count[4*g +: 4]),
            .carry_out (w_inc[g+1])
        );
    end

`ifdef DEC_CHAIN_LAP_EN
    logic [4*DIGITS-1:0] w_count_nxt;
    logic [4*DIGITS-1:0] r_lap_count;
    logic                r_lap_valid;

    // Lap captures the value the digits take on this same edge.
    for (genvar g = 0; g < DIGITS; g++) begin : g_lap_nxt
        assign w_count_nxt[4*g +: 4] = bcd_next(w_count[4*g +: 4], w_inc[g]);
    end

    // Lap capture register, only honoured while running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lap_count <= '0;
            r_lap_valid <= 1'b0;
        end else if (clear) begin
            r_lap_count <= '0;
            r_lap_valid <= 1'b0;
        end else if (lap && (r_state == ST_RUN)) begin
            r_lap_count <= w_count_nxt;
            r_lap_valid <= 1'b1;
        end
    end

    assign lap_count = r_lap_count;
    assign lap_valid = r_lap_valid;
`endif

    assign count    = w_count;
    assign running  = r_running;
    assign overflow = r_overflow;

endmodule
